// File: rtl/dm_store.sv
// Word-addressed data memory with sw/sh/sb byte-lane merging, misalign/range guards
// and a saturating write counter. Define DM_WRITE_LOG_EN to print one line per committed write.
module dm_store #(
    parameter int unsigned DEPTH = 3072
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] PC,
    input  logic [31:0] addr,
    input  logic [31:0] WD,
    input  logic [1:0]  store_type,
    output logic [31:0] RD,
    output logic        misalign,
    output logic        out_of_range,
    output logic [15:0] wr_count
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [1:0] ST_NONE = 2'b00;
    localparam logic [1:0] ST_SW   = 2'b01;
    localparam logic [1:0] ST_SH   = 2'b10;
    localparam logic [1:0] ST_SB   = 2'b11;

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] idx;
    logic [31:0]   merged;
    logic          commit;

    assign idx          = addr[AW+1:2];
    assign out_of_range = (addr[31:2] >= 30'(DEPTH));
    assign RD           = out_of_range ? 32'h0 : mem[idx];

    always_comb begin
        misalign = 1'b0;
        case (store_type)
            ST_SW:   misalign = (addr[1:0] != 2'b00);
            ST_SH:   misalign = addr[0];
            default: misalign = 1'b0;
        endcase
    end

    assign commit = (store_type != ST_NONE) && !misalign && !out_of_range && !reset;

    // Merge the store data into the currently stored word by byte lane.
    always_comb begin
        merged = RD;
        case (store_type)
            ST_SW: merged = WD;
            ST_SH: begin
                if (addr[1]) merged[31:16] = WD[15:0];
                else         merged[15:0]  = WD[15:0];
            end
            ST_SB: begin
                case (addr[1:0])
                    2'b00:   merged[7:0]   = WD[7:0];
                    2'b01:   merged[15:8]  = WD[7:0];
                    2'b10:   merged[23:16] = WD[7:0];
                    default: merged[31:24] = WD[7:0];
                endcase
            end
            default: merged = RD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= 32'h0;
            end
        end else if (commit) begin
            mem[idx] <= merged;
        end
    end

    // Counter holds at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_count <= 16'h0;
        end else if (commit && (wr_count != 16'hFFFF)) begin
            wr_count <= wr_count + 16'd1;
        end
    end

`ifdef DM_WRITE_LOG_EN
    always_ff @(posedge clk) begin
        if (commit) begin
            $display("@%08h: *%08h <= %08h", PC, {addr[31:2], 2'b00}, merged);
        end
    end
`else
    // PC only feeds the write log.
    logic unused_pc;
    assign unused_pc = ^PC;
`endif

endmodule

// File: tb/tb_dm_store.sv
// Directed self-checking bench for dm_store: lane merges, guards, reset collision, saturation.
module tb_dm_store;

    logic        clk;
    logic        reset;
    logic [31:0] PC;
    logic [31:0] addr;
    logic [31:0] WD;
    logic [1:0]  store_type;
    logic [31:0] RD;
    logic        misalign;
    logic        out_of_range;
    logic [15:0] wr_count;

    int n_checks = 0;
    int n_pass   = 0;

    dm_store #(.DEPTH(3072)) dut (
        .clk          (clk),
        .reset        (reset),
        .PC           (PC),
        .addr         (addr),
        .WD           (WD),
        .store_type   (store_type),
        .RD           (RD),
        .misalign     (misalign),
        .out_of_range (out_of_range),
        .wr_count     (wr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    endtask

    // Present a store at the falling edge, let it commit on the rising edge, then idle.
    task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] t);
        @(negedge clk);
        PC = PC + 32'd4;
        addr = a;
        WD = d;
        store_type = t;
        @(posedge clk);
        #1;
        store_type = 2'b00;
    endtask

    task automatic read_check(input string tag, input logic [31:0] a, input logic [31:0] exp);
        store_type = 2'b00;
        addr = a;
        #1;
        check(tag, RD, exp);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        PC = 32'h0000_3000;
        addr = 32'h0;
        WD = 32'h0;
        store_type = 2'b00;

        // Reset state
        do_reset();
        read_check("rst_rd0", 32'h0000, 32'h0);
        read_check("rst_rd_last", 32'h2FFC, 32'h0);
        check("rst_cnt", 32'(wr_count), 32'h0);

        // sw, including old-data read in the write cycle
        @(negedge clk);
        PC = PC + 32'd4;
        addr = 32'h0004;
        WD = 32'h1234_5678;
        store_type = 2'b01;
        #1;
        check("sw_old_word", RD, 32'h0);
        @(posedge clk);
        #1;
        store_type = 2'b00;
        read_check("sw_rd", 32'h0004, 32'h1234_5678);
        check("sw_cnt", 32'(wr_count), 32'd1);

        // sh / sb merges
        store(32'h0008, 32'hAABB_CCDD, 2'b01);
        read_check("merge_base", 32'h0008, 32'hAABB_CCDD);
        store(32'h000A, 32'h0000_1122, 2'b10);
        read_check("sh_hi", 32'h0008, 32'h1122_CCDD);
        store(32'h0009, 32'h0000_00EE, 2'b11);
        read_check("sb_lane1", 32'h0008, 32'h1122_EEDD);
        store(32'h0008, 32'hFFFF_5566, 2'b10);
        read_check("sh_lo", 32'h0008, 32'h1122_5566);
        store(32'h000B, 32'h1234_5677, 2'b11);
        read_check("sb_lane3", 32'h0008, 32'h7722_5566);
        check("merge_cnt", 32'(wr_count), 32'd6);

        // Misalignment
        addr = 32'h0006; store_type = 2'b01; #1;
        check("mis_sw", 32'(misalign), 32'd1);
        addr = 32'h0005; store_type = 2'b10; #1;
        check("mis_sh", 32'(misalign), 32'd1);
        addr = 32'h0006; store_type = 2'b10; #1;
        check("mis_sh_ok", 32'(misalign), 32'd0);
        addr = 32'h0007; store_type = 2'b11; #1;
        check("mis_sb_ok", 32'(misalign), 32'd0);
        addr = 32'h0003; store_type = 2'b00; #1;
        check("mis_none", 32'(misalign), 32'd0);
        store_type = 2'b00;
        store(32'h0006, 32'hDEAD_BEEF, 2'b01);
        store(32'h0005, 32'hDEAD_BEEF, 2'b10);
        read_check("mis_word", 32'h0004, 32'h1234_5678);
        check("mis_cnt", 32'(wr_count), 32'd6);

        // Range boundary
        addr = 32'h3000; #1;
        check("oor_flag", 32'(out_of_range), 32'd1);
        check("oor_rd", RD, 32'h0);
        addr = 32'h2FFC; #1;
        check("inr_flag", 32'(out_of_range), 32'd0);
        store(32'h3000, 32'h5555_5555, 2'b01);
        check("oor_cnt", 32'(wr_count), 32'd6);
        read_check("oor_alias0", 32'h0000, 32'h0);
        store(32'h2FFC, 32'hCAFE_F00D, 2'b01);
        read_check("last_word", 32'h2FFC, 32'hCAFE_F00D);
        check("last_cnt", 32'(wr_count), 32'd7);

        // Reset collides with a store
        @(negedge clk);
        reset = 1'b1;
        addr = 32'h0000;
        WD = 32'hFFFF_FFFF;
        store_type = 2'b01;
        @(posedge clk);
        #1;
        reset = 1'b0;
        store_type = 2'b00;
        read_check("col_rd0", 32'h0000, 32'h0);
        read_check("col_rd8", 32'h0008, 32'h0);
        read_check("col_rd_last", 32'h2FFC, 32'h0);
        check("col_cnt", 32'(wr_count), 32'h0);

        // Saturation: one committed sb per cycle
        @(negedge clk);
        addr = 32'h0010;
        WD = 32'h0000_00A5;
        store_type = 2'b11;
        repeat (65534) @(posedge clk);
        #1;
        check("sat_fffe", 32'(wr_count), 32'h0000_FFFE);
        @(posedge clk);
        #1;
        check("sat_ffff", 32'(wr_count), 32'h0000_FFFF);
        repeat (3) @(posedge clk);
        #1;
        check("sat_hold", 32'(wr_count), 32'h0000_FFFF);
        store_type = 2'b00;
        read_check("sat_word", 32'h0010, 32'h0000_00A5);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/dm_store.md
DM_STORE -- requirements
Module: dm_store

Interface
REQ-001 SHALL have parameter DEPTH, default 3072, meaning the number of 32-bit words (byte range 0x0000-0x2FFF).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port PC, input, 32 bits: the address of the current store instruction, used only for logging.
REQ-005 SHALL have port addr, input, 32 bits: the byte address from the ALU.
REQ-006 SHALL have port WD, input, 32 bits: the store data from rt.
REQ-007 SHALL have port store_type, input, 2 bits: 00 none, 01 sw, 10 sh, 11 sb.
REQ-008 SHALL have port RD, output, 32 bits: the raw aligned word, which the downstream load-extension stage consumes.
REQ-009 SHALL have port misalign, output, 1 bit: the current store is misaligned.
REQ-010 SHALL have port out_of_range, output, 1 bit: addr[31:2] >= DEPTH.
REQ-011 SHALL have port wr_count, output, 16 bits: the number of committed writes since reset.

Function
REQ-012 SHALL drive RD combinationally as mem[addr[31:2]]: no byte selection, no extension, and 32'h0 when out_of_range=1.
REQ-013 SHALL assert misalign combinationally for sw with addr[1:0]!=0, or for sh with addr[0]!=0; otherwise misalign=0, and it is always 0 for store_type=00.
REQ-014 SHALL commit a write on the rising edge only when store_type!=00, misalign=0, out_of_range=0 and reset=0.
REQ-015 SHALL on a sw write WD to all four byte lanes.
REQ-016 SHALL on a sh with addr[1]=0 write WD[15:0] to bytes 1:0, and with addr[1]=1 write WD[15:0] to bytes 3:2; other bytes are unchanged.
REQ-017 SHALL on a sb write WD[7:0] to byte lane addr[1:0]; other bytes are unchanged.
REQ-018 SHALL, for a read to the same word in the cycle of a write, show the old word that cycle and the merged word from the next cycle.
REQ-019 SHALL increment wr_count by 1 on each committed write and saturate at 16'hFFFF without wrapping.
REQ-020 SHALL silently drop suppressed writes (misaligned or out of range), leaving memory and wr_count unchanged.

Reset
REQ-021 SHALL, on a rising edge with reset=1, clear every memory word to 32'h0 and wr_count to 0.
REQ-022 SHALL give reset priority over a store in the same cycle: no write and no log.
REQ-023 SHALL produce RD=0 for every address in the cycle after reset; misalign and out_of_range depend only on inputs.

Configuration
REQ-024 SHALL, with macro DM_WRITE_LOG_EN defined, print one line per committed write at the clock edge in the form "@<PC hex8>: *<word-aligned addr hex8> <= <merged full word hex8>".
REQ-025 SHALL, without DM_WRITE_LOG_EN, print nothing and otherwise behave identically.

Verification
REQ-026 SHALL cover sw: reset, then sw addr=0x0004 WD=0x12345678 -> next cycle RD@0x0004=0x12345678, wr_count=1, and the log line "*00000004 <= 12345678" when the macro is enabled.
REQ-027 SHALL cover sh and sb merge: word 0x0008=0xAABBCCDD, then sh addr=0x000A WD=0x00001122 gives 0x1122CCDD, then sb addr=0x0009 WD=0x000000EE gives 0x1122EEDD.
REQ-028 SHALL cover misalignment: sw addr=0x0006, or sh addr=0x0005 -> misalign=1, word unchanged, wr_count unchanged, no log.
REQ-029 SHALL cover range and saturation: sw addr=0x3000 -> out_of_range=1, RD=0, no write; 65536 valid sb stores -> wr_count stays at 0xFFFF.
REQ-030 SHALL cover reset collision: reset=1 together with sw addr=0x0000 WD=0xFFFFFFFF -> RD@0=0 and wr_count=0 after the edge.
